// File: rtl/tick_window_gen.sv
// ============================================================================
// Module   : tick_window_gen
// Brief    : Tick-timed window generator. On an accepted start it waits
//            cfg_delay prescaler ticks, holds win for cfg_width ticks, then
//            pulses done for one cycle. Abort cancels without a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tick_window_gen #(
  parameter int DLY_W = 8,
  parameter int WID_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  output logic             busy,
  output logic             win,
  output logic             done,
  output logic             start_err
);

  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_ZERO = '0;
  localparam logic [WID_W-1:0] WID_ONE  = WID_W'(1);
  localparam logic [WID_W-1:0] WID_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_nxt;
  logic [WID_W-1:0] wid_cnt;
  logic [WID_W-1:0] wid_nxt;
  logic             err_nxt;

  // Next-state and counter update; a zero count is never entered, so the
  // down-counters only decrement from values >= 2 and cannot wrap.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    wid_nxt   = wid_cnt;
    err_nxt   = start && (state != S_IDLE) && !abort;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          dly_nxt = cfg_delay;
          wid_nxt = cfg_width;
          if (cfg_delay != DLY_ZERO) begin
            state_nxt = S_DELAY;
          end else if (cfg_width != WID_ZERO) begin
            state_nxt = S_ACTIVE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DELAY: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dly_nxt   = DLY_ZERO;
          wid_nxt   = WID_ZERO;
        end else if (tick) begin
          if (dly_cnt == DLY_ONE) begin
            dly_nxt   = DLY_ZERO;
            // A zero width skips the window entirely.
            state_nxt = (wid_cnt != WID_ZERO) ? S_ACTIVE : S_DONE;
          end else begin
            dly_nxt = dly_cnt - DLY_ONE;
          end
        end
      end

      S_ACTIVE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dly_nxt   = DLY_ZERO;
          wid_nxt   = WID_ZERO;
        end else if (tick) begin
          if (wid_cnt == WID_ONE) begin
            wid_nxt   = WID_ZERO;
            state_nxt = S_DONE;
          end else begin
            wid_nxt = wid_cnt - WID_ONE;
          end
        end
      end

      S_DONE: begin
        // Single-cycle completion state; start is ignored here.
        state_nxt = S_IDLE;
        dly_nxt   = DLY_ZERO;
        wid_nxt   = WID_ZERO;
      end

      default: begin
        state_nxt = S_IDLE;
        dly_nxt   = DLY_ZERO;
        wid_nxt   = WID_ZERO;
      end
    endcase
  end

  // State, counters and status outputs; outputs are registered from the
  // next state so they never depend combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dly_cnt   <= DLY_ZERO;
      wid_cnt   <= WID_ZERO;
      busy      <= 1'b0;
      win       <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      dly_cnt   <= dly_nxt;
      wid_cnt   <= wid_nxt;
      busy      <= (state_nxt != S_IDLE);
      win       <= (state_nxt == S_ACTIVE);
      done      <= (state_nxt == S_DONE);
      start_err <= err_nxt;
    end
  end

  // Output relationships that must hold in every cycle out of reset.
  a_done_single : assert property (@(posedge clk) disable iff (!rst_n)
                                   done |=> !done);
  a_win_busy    : assert property (@(posedge clk) disable iff (!rst_n)
                                   win |-> busy);
  a_done_nowin  : assert property (@(posedge clk) disable iff (!rst_n)
                                   done |-> !win);
  a_dly_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == S_DELAY) |-> (dly_cnt != DLY_ZERO));
  a_wid_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == S_ACTIVE) |-> (wid_cnt != WID_ZERO));

endmodule

`default_nettype wire

// File: tb/tb_tick_window_gen.sv
// ============================================================================
// Module   : tb_tick_window_gen
// Brief    : Self-checking bench for tick_window_gen. A reference model counts
//            ticks since start and derives busy/win/done from the delay and
//            width totals; directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tick_window_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_delay = 8'd0;
  logic [7:0] cfg_width = 8'd0;
  logic       busy;
  logic       win;
  logic       done;
  logic       start_err;

  int n_checks = 0;
  int n_pass   = 0;
  int win_cnt  = 0;
  int done_cnt = 0;

  // Reference model: a sequence is in progress, n ticks have been counted
  // since the accept cycle, window covers tick counts [D, D+W), done at D+W.
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_d      = 0;
  int m_w      = 0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  tick_window_gen #(
    .DLY_W(8),
    .WID_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .abort    (abort),
    .cfg_delay(cfg_delay),
    .cfg_width(cfg_width),
    .busy     (busy),
    .win      (win),
    .done     (done),
    .start_err(start_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit m_win();
    return m_active && (m_n >= m_d) && (m_n < m_d + m_w);
  endfunction

  function automatic bit m_done();
    return m_active && (m_n == m_d + m_w);
  endfunction

  task automatic model_update(input bit s, input bit a, input bit t, input int d, input int w);
    bit fin;
    fin   = m_done();
    m_err = s && m_active && !a;
    if (!m_active) begin
      if (s && !a) begin
        m_active = 1'b1;
        m_n      = 0;
        m_d      = d;
        m_w      = w;
      end
    end else if (a || fin) begin
      m_active = 1'b0;
    end else if (t) begin
      m_n++;
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit s, input bit a, input bit t, input int d, input int w);
    @(negedge clk);
    check_eq("busy", busy, m_active);
    check_eq("win", win, m_win());
    check_eq("done", done, m_done());
    check_eq("start_err", start_err, m_err);
    if (win === 1'b1) win_cnt++;
    if (done === 1'b1) done_cnt++;
    start     = s;
    abort     = a;
    tick      = t;
    cfg_delay = d[7:0];
    cfg_width = w[7:0];
    @(posedge clk);
    model_update(s, a, t, d, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_win", win, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", start_err, 0);
    m_active = 1'b0;
    m_err    = 1'b0;
    m_n      = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_active && k < 2000) begin
      step(0, 0, 1, 0, 0);
      k++;
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();

    // Reset in the middle of the window, then a normal sequence.
    step(1, 0, 0, 2, 5);
    repeat (4) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 1, 1);
    wait_idle();

    // Tick every 4 cycles, start at cycle 10 with D=3, W=2.
    for (int c = 0; c < 40; c++) step(c == 10, 0, (c % 4) == 3, 3, 2);
    wait_idle();

    // Zero delay, zero width, both zero.
    step(1, 0, 0, 0, 3);
    wait_idle();
    win_cnt = 0;
    step(1, 0, 0, 4, 0);
    for (int c = 0; c < 14; c++) step(0, 0, c % 2, 0, 0);
    wait_idle();
    check_eq("w0_no_win", win_cnt, 0);
    done_cnt = 0;
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("d0w0_done", done_cnt, 1);

    // Maximum counts with tick continuously high.
    win_cnt  = 0;
    done_cnt = 0;
    step(1, 0, 1, 255, 255);
    wait_idle();
    check_eq("max_win_len", win_cnt, 255);
    check_eq("max_done_once", done_cnt, 1);

    // Start held high with changing configuration.
    step(1, 0, 1, 2, 3);
    for (int c = 0; c < 24; c++) step(1, 0, c % 2, c + 7, c + 9);
    wait_idle();

    // Abort in DELAY together with a tick; abort+start in IDLE.
    done_cnt = 0;
    win_cnt  = 0;
    step(1, 0, 0, 3, 2);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_no_win", win_cnt, 0);
    step(1, 1, 0, 2, 2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic including aborts in every state and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      step(($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 3) != 0,
           int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
